// File: rtl/uart_ctrl_pkg.sv
// Shared UART controller definitions: TX FIFO sizing, character type and
// the push/pop operation encoding used by the FIFO count update and coverage.
package uart_ctrl_pkg;

  localparam int unsigned UART_TX_FIFO_DEPTH = 16;
  localparam int unsigned UART_DATA_W        = 8;

  typedef logic [UART_DATA_W-1:0] uart_char_t;

  // Accepted operations in one cycle: bit 1 = pop, bit 0 = push
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the THR write path / TX serialiser and the TX FIFO.
// Optional watermark signals exist only with UART_TX_FIFO_WATERMARK_EN defined.
interface uart_tx_fifo_if
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int unsigned DATA_W = UART_DATA_W
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              clear;
  logic              full;
  logic              empty;
  logic              thre;
  logic [PTR_W:0]    fifo_ptr;
  logic              overflow;
`ifdef UART_TX_FIFO_WATERMARK_EN
  logic [PTR_W:0]    thresh;
  logic              below_thresh;

  modport master (
    output push, push_data, pop, clear, thresh,
    input  pop_data, full, empty, thre, fifo_ptr, overflow, below_thresh
  );

  modport slave (
    input  push, push_data, pop, clear, thresh,
    output pop_data, full, empty, thre, fifo_ptr, overflow, below_thresh
  );
`else
  modport master (
    output push, push_data, pop, clear,
    input  pop_data, full, empty, thre, fifo_ptr, overflow
  );

  modport slave (
    input  push, push_data, pop, clear,
    output pop_data, full, empty, thre, fifo_ptr, overflow
  );
`endif

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read of the addressed entry
  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: first-word-fall-through buffer between THR writes and
// the TX serialiser, with 16550-style clear, THR-empty and sticky overflow.
// Optional feature macro: UART_TX_FIFO_WATERMARK_EN (adds thresh/below_thresh).
module uart_tx_fifo
  import uart_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH  = UART_TX_FIFO_DEPTH,
  parameter  int unsigned DATA_W = UART_DATA_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input logic           clock,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             thre_q;
  logic             overflow_q;
  logic             full_c;
  logic             empty_c;
  logic             push_acc;
  logic             pop_acc;
  logic             ovf_set;
  fifo_op_e         op;

  // Flags come from the registered occupancy, not from pointer compare
  assign full_c  = (count == (PTR_W+1)'(DEPTH));
  assign empty_c = (count == '0);

  // Clear wins over both strobes; a pop frees a slot for a same-cycle push
  assign pop_acc  = bus.pop && !empty_c && !bus.clear;
  assign push_acc = bus.push && (!full_c || bus.pop) && !bus.clear;
  assign ovf_set  = bus.push && full_c && !bus.pop && !bus.clear;
  assign op       = fifo_op_e'({pop_acc, push_acc});

  // Next-state occupancy
  always_comb begin
    count_nxt = count;
    if (bus.clear) begin
      count_nxt = '0;
    end else begin
      case (op)
        OP_PUSH: count_nxt = count + (PTR_W+1)'(1);
        OP_POP:  count_nxt = count - (PTR_W+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers, occupancy, THR-empty and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      thre_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (bus.clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_nxt;
      thre_q <= (count_nxt == '0);
      if (bus.clear) begin
        overflow_q <= 1'b0;
      end else if (ovf_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_WATERMARK_EN
  logic below_q;

  // Early refill request from the next-state occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      below_q <= 1'b1;
    end else begin
      below_q <= (count_nxt < bus.thresh);
    end
  end

  assign bus.below_thresh = below_q;
`endif

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock (clock),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (bus.push_data),
    .raddr (rd_ptr),
    .rdata (bus.pop_data)
  );

  assign bus.fifo_ptr = count;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.thre     = thre_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo against a queue-based model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: contents in order, sticky overflow, threshold
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_thresh = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".fifo_ptr"}, 32'(bus.fifo_ptr), 32'(mq.size()));
    chk({tag, ".empty"},    32'(bus.empty),    32'(mq.size() == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(mq.size() == DEPTH));
    chk({tag, ".thre"},     32'(bus.thre),     32'(mq.size() == 0));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_TX_FIFO_WATERMARK_EN
    chk({tag, ".below_thresh"}, 32'(bus.below_thresh), 32'(mq.size() < m_thresh));
`endif
  endtask

  // One clock of stimulus; head data checked before the edge, state after
  task automatic step(input bit p, input logic [7:0] d, input bit o, input bit c);
    bit pacc;
    bit wacc;
    @(negedge clock);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = o;
    bus.clear     = c;
    #1;
    if (mq.size() > 0) chk("pop_data", 32'(bus.pop_data), 32'(mq[0]));
    @(posedge clock);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pacc = o && (mq.size() > 0);
      wacc = p && ((mq.size() < DEPTH) || o);
      if (pacc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
      if (p && !wacc) m_ovf = 1'b1;
    end
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
    check_state("step");
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    bus.pop       = 1'b0;
    bus.clear     = 1'b0;
`ifdef UART_TX_FIFO_WATERMARK_EN
    bus.thresh    = 5'd4;
`endif

    // Reset values
    repeat (2) @(negedge clock);
    check_state("reset");
    reset = 1'b0;

    // Three pushes then three pops, in order
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("p3.ptr1", 32'(bus.fifo_ptr), 32'd1);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    chk("p3.ptr2", 32'(bus.fifo_ptr), 32'd2);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("p3.ptr3", 32'(bus.fifo_ptr), 32'd3);
    chk("p3.empty", 32'(bus.empty), 32'd0);
    @(negedge clock);
    chk("p3.head", 32'(bus.pop_data), 32'h41);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("p3.thre", 32'(bus.thre), 32'd1);

    // Fill, overflow push is dropped, drain in order
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf.full", 32'(bus.full), 32'd1);
    chk("ovf.ptr", 32'(bus.fifo_ptr), 32'd16);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf.cleared", 32'(bus.overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fpp.ptr", 32'(bus.fifo_ptr), 32'd16);
    chk("fpp.ovf", 32'(bus.overflow), 32'd0);
    repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with simultaneous push and pop: pop ignored
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    chk("epp.ptr", 32'(bus.fifo_ptr), 32'd1);
    @(negedge clock);
    chk("epp.head", 32'(bus.pop_data), 32'h7E);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_TX_FIFO_WATERMARK_EN
    // Watermark at 4
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("wm.push", 32'(bus.below_thresh), 32'(i < 3));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wm.pop", 32'(bus.below_thresh), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Random traffic with pointer wrap; push-biased then pop-biased
    for (int i = 0; i < 240; i++) begin
      bit p;
      bit o;
      bit c;
      p = (i < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      o = (i < 120) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      step(p, 8'($urandom), o, c);
    end

    // Bring occupancy to 5, then clear with a same-cycle push
    while (mq.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
    while (mq.size() < 5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("clr.pre", 32'(bus.fifo_ptr), 32'd5);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("clr.ptr", 32'(bus.fifo_ptr), 32'd0);
    chk("clr.empty", 32'(bus.empty), 32'd1);
    chk("clr.ovf", 32'(bus.overflow), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_state("async_rst");
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side data FIFO of the UART controller, between the APB/THR register write path and the TX serialiser.
- Buffers characters written by software and hands them in order to the shift register.
- Exports its live occupancy as fifo_ptr, which drives tx_fifo_ptr of the white-box coverage interface.
- Compatible with 16550-style FIFO semantics: clear via FCR, THR-empty status.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2, at least 2.
- DATA_W, 8, character width in bits.
- PTR_W, $clog2(DEPTH), derived; read/write address width.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  write strobe from THR write decode.
- push_data  in  DATA_W  character to enqueue.
- pop  in  1  dequeue strobe from TX serialiser when loading its shift register.
- pop_data  out  DATA_W  head entry, first-word-fall-through.
- clear  in  1  FCR TX-FIFO reset bit, single-cycle pulse.
- full  out  1  fifo_ptr == DEPTH.
- empty  out  1  fifo_ptr == 0.
- thre  out  1  THR-empty status; registered copy of empty.
- fifo_ptr  out  PTR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky; push attempted while full and not popped.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, fifo_ptr=0, empty=1, full=0, thre=1, overflow=0. Memory contents are not reset. pop_data is don't-care while empty.
- Storage: DEPTH x DATA_W register array. wr_ptr and rd_ptr are PTR_W bits and wrap naturally from DEPTH-1 to 0.
- Push accepted if push && (!full || pop): mem[wr_ptr]<=push_data, wr_ptr++.
- Pop accepted if pop && !empty: rd_ptr++. pop_data = mem[rd_ptr] combinationally (zero-latency read of the head).
- Count update, per cycle:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged on both accepted or neither.
  - full/empty are derived from the registered fifo_ptr, never from pointer compare.
- Boundary cases:
  - Full, push+pop same cycle: both accepted, fifo_ptr stays DEPTH.
  - Empty, push+pop same cycle: pop ignored, push accepted, fifo_ptr becomes 1. pop_data shows the new entry the next cycle.
  - Push while full without pop: data dropped, pointers unchanged, overflow<=1.
  - Pop while empty: ignored. No underflow flag. Serialiser must gate pop with !empty.
- clear has priority over push and pop in the same cycle: pointers and fifo_ptr go to 0 and overflow goes to 0. A push in the clear cycle is discarded.
- thre <= empty next-state, i.e. it goes high the cycle fifo_ptr reaches 0.
- Reset mid-operation: all state returns to reset values immediately. A partially popped character is lost; no recovery.

Optional Feature:
- Macro: UART_TX_FIFO_WATERMARK_EN.
- With the macro defined, two extra ports are added:
  - thresh  in  PTR_W+1  programmable level.
  - below_thresh  out  1  registered; 1 when next-state fifo_ptr < thresh; reset value 1.
- The TX interrupt logic uses below_thresh as an early refill request.
- Without the macro, neither port exists and no related logic is generated; behaviour is otherwise identical.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - UART_TX_FIFO_DEPTH (16) and UART_DATA_W (8) constants.
  - typedef logic [UART_DATA_W-1:0] uart_char_t.
  - typedef enum for push/pop op encoding (OP_NONE, OP_PUSH, OP_POP, OP_BOTH), used by the RTL count update and by coverage.
- One natural sub-module: uart_fifo_mem, the DEPTH x DATA_W register array with write port and async read port.
- Pointer, count and flag control stay in uart_tx_fifo.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles -> fifo_ptr 1,2,3; empty=0. Three pops -> pop_data 0x41,0x42,0x43 in order; fifo_ptr 0, thre=1 one cycle after the last pop.
- Push 16 entries 0x00..0x0F, then push 0xAA -> full=1, fifo_ptr=16, overflow=1. Draining yields 0x00..0x0F; 0xAA never appears.
- Fill to 16, then push 0x55 with simultaneous pop -> pop_data 0x00 consumed, fifo_ptr stays 16, overflow=0, 0x55 emerges as the 16th subsequent pop.
- Empty FIFO, push 0x7E with simultaneous pop -> fifo_ptr=1; next cycle pop_data=0x7E.
- 20 push/pop cycles for wrap-around, then fifo_ptr=5 plus clear+push in the same cycle -> fifo_ptr=0, empty=1, overflow=0, pushed data discarded.
- With UART_TX_FIFO_WATERMARK_EN and thresh=4: push 4 -> below_thresh 1,1,1,0; pop 1 -> below_thresh=1.
